// File: rtl/mc_ctrl_pkg.sv
// Shared control definitions for the multicycle CPU: state codes, opcodes and
// ALU operation codes, reused by the decoder, ALU control and datapath.
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [2:0] {
    ALU_RTYPE = 3'd0,
    ALU_ADDI  = 3'd1,
    ALU_SLTIU = 3'd2,
    ALU_BEQ   = 3'd3,
    ALU_LUI   = 3'd4,
    ALU_ORI   = 3'd5,
    ALU_BNE   = 3'd6,
    ALU_MEM   = 3'd7
  } alu_op_e;

  function automatic logic is_legal_op(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_ADDI, OP_SLTIU, OP_BEQ, OP_BNE,
      OP_LUI, OP_ORI, OP_LW, OP_SW: return 1'b1;
      default:                      return 1'b0;
    endcase
  endfunction

  function automatic alu_op_e alu_code(input logic [5:0] op);
    case (op)
      OP_ADDI:      return ALU_ADDI;
      OP_SLTIU:     return ALU_SLTIU;
      OP_BEQ:       return ALU_BEQ;
      OP_BNE:       return ALU_BNE;
      OP_LUI:       return ALU_LUI;
      OP_ORI:       return ALU_ORI;
      OP_LW, OP_SW: return ALU_MEM;
      default:      return ALU_RTYPE;
    endcase
  endfunction

endpackage

// File: rtl/mc_decoder_if.sv
// Control bus between the multicycle decoder (master) and the datapath it
// steers (slave).
interface mc_decoder_if #(
  parameter int ALUOP_W = 3,
  parameter int RET_W   = 16
);
  logic [5:0]         instr_op_i;
  logic               mem_ready_i;
  logic               PCWrite_o;
  logic               IRWrite_o;
  logic               MemRead_o;
  logic               MemWrite_o;
  logic               RegWrite_o;
  logic [ALUOP_W-1:0] ALU_op_o;
  logic               ALUSrc_o;
  logic               RegDst_o;
  logic               MemToReg_o;
  logic               Branch_o;
  logic               BranchNe_o;
  logic [2:0]         state_o;
  logic               illegal_o;
  logic               mem_err_o;
  logic [RET_W-1:0]   retired_o;

  modport master (
    input  instr_op_i, mem_ready_i,
    output PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, RegWrite_o,
           ALU_op_o, ALUSrc_o, RegDst_o, MemToReg_o, Branch_o, BranchNe_o,
           state_o, illegal_o, mem_err_o, retired_o
  );

  modport slave (
    output instr_op_i, mem_ready_i,
    input  PCWrite_o, IRWrite_o, MemRead_o, MemWrite_o, RegWrite_o,
           ALU_op_o, ALUSrc_o, RegDst_o, MemToReg_o, Branch_o, BranchNe_o,
           state_o, illegal_o, mem_err_o, retired_o
  );
endinterface

// File: rtl/mc_wait_timer.sv
// Counts consecutive memory wait cycles; expired_o flags that the count has
// reached MEM_TIMEOUT. Clear has priority over count-enable.
module mc_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic clr_i,
  output logic expired_o
);
  localparam int              CNT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MEM_TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == LIMIT);

endmodule

// File: rtl/mc_decoder.sv
// Multicycle CPU main control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing with
// memory wait timeout, illegal-opcode detection and a retired-instruction count.
module mc_decoder
  import mc_ctrl_pkg::*;
#(
  parameter int ALUOP_W     = 3,
  parameter int RET_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mc_decoder_if.master  bus
);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [RET_W-1:0] ret_q;

  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic       alu_src, reg_dst, mem_to_reg, branch, branch_ne;
  logic       illegal, mem_err, retire, wait_state;
  logic [2:0] alu_op;
  logic       expired, timer_en, timer_clr;

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    branch     = 1'b0;
    branch_ne  = 1'b0;
    illegal    = 1'b0;
    mem_err    = 1'b0;
    retire     = 1'b0;
    wait_state = 1'b0;
    alu_op     = ALU_RTYPE;

    case (state_q)
      S_DECODE: begin
        op_d = bus.instr_op_i;
        if (is_legal_op(bus.instr_op_i)) begin
          state_d = S_EXEC;
        end else begin
          illegal = 1'b1;
          state_d = S_FETCH;
        end
      end

      S_EXEC: begin
        alu_op  = alu_code(op_q);
        alu_src = !(op_q == OP_RTYPE || op_q == OP_BEQ || op_q == OP_BNE);
        if (op_q == OP_BEQ || op_q == OP_BNE) begin
          branch    = (op_q == OP_BEQ);
          branch_ne = (op_q == OP_BNE);
          retire    = 1'b1;
          state_d   = S_FETCH;
        end else if (op_q == OP_LW || op_q == OP_SW) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end

      S_MEM: begin
        wait_state = 1'b1;
        alu_op     = alu_code(op_q);
        mem_read   = (op_q == OP_LW);
        mem_write  = (op_q != OP_LW);
        if (bus.mem_ready_i) begin
          state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
          retire  = (op_q != OP_LW);
        end else if (expired) begin
          // Abort the access: the store strobe must not be seen with the error.
          mem_err   = 1'b1;
          mem_write = 1'b0;
          state_d   = S_FETCH;
        end
      end

      S_WB: begin
        reg_write  = 1'b1;
        reg_dst    = (op_q == OP_RTYPE);
        mem_to_reg = (op_q == OP_LW);
        retire     = 1'b1;
        state_d    = S_FETCH;
      end

      default: begin
        // FETCH, and any unreachable code which is treated as FETCH.
        wait_state = 1'b1;
        mem_read   = 1'b1;
        state_d    = S_FETCH;
        if (bus.mem_ready_i) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (expired) begin
          mem_err = 1'b1;
        end
      end
    endcase
  end

  assign timer_en  = wait_state & ~bus.mem_ready_i;
  assign timer_clr = (state_d != state_q) | bus.mem_ready_i | mem_err;

  mc_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_wait_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (timer_en),
    .clr_i     (timer_clr),
    .expired_o (expired)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      ret_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      if (retire) begin
        ret_q <= ret_q + 1'b1;
      end
    end
  end

  // Reset holds every control strobe low combinationally, not just after the edge.
  assign bus.PCWrite_o  = rst_i & pc_write;
  assign bus.IRWrite_o  = rst_i & ir_write;
  assign bus.MemRead_o  = rst_i & mem_read;
  assign bus.MemWrite_o = rst_i & mem_write;
  assign bus.RegWrite_o = rst_i & reg_write;
  assign bus.ALUSrc_o   = rst_i & alu_src;
  assign bus.RegDst_o   = rst_i & reg_dst;
  assign bus.MemToReg_o = rst_i & mem_to_reg;
  assign bus.Branch_o   = rst_i & branch;
  assign bus.BranchNe_o = rst_i & branch_ne;
  assign bus.illegal_o  = rst_i & illegal;
  assign bus.mem_err_o  = rst_i & mem_err;
  assign bus.ALU_op_o   = rst_i ? ALUOP_W'(alu_op) : '0;
  assign bus.state_o    = rst_i ? state_q : 3'd0;
  assign bus.retired_o  = ret_q;

endmodule

// File: tb/tb_mc_decoder.sv
// Self-checking bench for mc_decoder: each instruction is planned cycle by
// cycle from the control rules and every output is compared every cycle.
module tb_mc_decoder;

  localparam int ALUOP_W = 4;
  localparam int RET_W   = 2;
  localparam int T       = 4;

  localparam logic [5:0] OPS  [9] = '{6'h00, 6'h08, 6'h0B, 6'h04, 6'h05,
                                      6'h0F, 6'h0D, 6'h23, 6'h2B};
  localparam int         ALUS [9] = '{0, 1, 2, 3, 6, 4, 5, 7, 7};

  localparam logic [5:0] R_OP    = 6'h00;
  localparam logic [5:0] ADDI_OP = 6'h08;
  localparam logic [5:0] BEQ_OP  = 6'h04;
  localparam logic [5:0] BNE_OP  = 6'h05;
  localparam logic [5:0] LW_OP   = 6'h23;
  localparam logic [5:0] SW_OP   = 6'h2B;

  typedef enum int {PH_FETCH = 0, PH_DECODE = 1, PH_EXEC = 2, PH_MEM = 3, PH_WB = 4} phase_e;

  typedef struct packed {
    logic [2:0]         st;
    logic               pcw, irw, mr, mw, rw;
    logic [ALUOP_W-1:0] alu;
    logic               asrc, rdst, m2r, br, bne, ill, merr;
  } vec_t;

  typedef struct {
    phase_e ph;
    logic   rdy;
    logic   to;
  } cyc_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  int   checks    = 0;
  int   errors    = 0;
  int   ret_model = 0;

  mc_decoder_if #(.ALUOP_W(ALUOP_W), .RET_W(RET_W)) bus ();

  mc_decoder #(
    .ALUOP_W     (ALUOP_W),
    .RET_W       (RET_W),
    .MEM_TIMEOUT (T)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic is_legal(input logic [5:0] op);
    for (int i = 0; i < 9; i++) if (OPS[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [ALUOP_W-1:0] alu_of(input logic [5:0] op);
    for (int i = 0; i < 9; i++) if (OPS[i] == op) return ALUOP_W'(ALUS[i]);
    return '0;
  endfunction

  function automatic vec_t sample();
    vec_t v;
    v.st   = bus.state_o;
    v.pcw  = bus.PCWrite_o;
    v.irw  = bus.IRWrite_o;
    v.mr   = bus.MemRead_o;
    v.mw   = bus.MemWrite_o;
    v.rw   = bus.RegWrite_o;
    v.alu  = bus.ALU_op_o;
    v.asrc = bus.ALUSrc_o;
    v.rdst = bus.RegDst_o;
    v.m2r  = bus.MemToReg_o;
    v.br   = bus.Branch_o;
    v.bne  = bus.BranchNe_o;
    v.ill  = bus.illegal_o;
    v.merr = bus.mem_err_o;
    return v;
  endfunction

  // Expected outputs for one cycle of a given phase, from the control rules.
  function automatic vec_t expect_vec(input phase_e ph, input logic [5:0] op,
                                      input logic rdy, input logic to);
    vec_t v = '0;
    v.st = 3'(ph);
    case (ph)
      PH_FETCH: begin
        v.mr   = 1'b1;
        v.irw  = rdy;
        v.pcw  = rdy;
        v.merr = to;
      end
      PH_DECODE: v.ill = !is_legal(op);
      PH_EXEC: begin
        v.alu  = alu_of(op);
        v.asrc = !(op == R_OP || op == BEQ_OP || op == BNE_OP);
        v.br   = (op == BEQ_OP);
        v.bne  = (op == BNE_OP);
      end
      PH_MEM: begin
        v.alu  = alu_of(op);
        v.mr   = (op == LW_OP);
        v.mw   = (op == SW_OP) && !to;
        v.merr = to;
      end
      default: begin
        v.rw   = 1'b1;
        v.rdst = (op == R_OP);
        v.m2r  = (op == LW_OP);
      end
    endcase
    return v;
  endfunction

  // Drive one cycle's inputs, sample #1 later, then advance to the next negedge.
  task automatic step(input logic [5:0] op, input logic rdy, output vec_t obs);
    bus.instr_op_i  = op;
    bus.mem_ready_i = rdy;
    #1;
    obs = sample();
    @(negedge clk_i);
  endtask

  // fw: not-ready FETCH cycles before the fetch completes; mw: not-ready MEM
  // cycles before the access completes (a timeout may cut it short).
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                           input string tag);
    cyc_t   plan[$];
    bit     retires = 1'b0;
    vec_t   obs, e;
    phase_e ph;
    logic [5:0] drv;

    for (int i = 0; i < fw; i++) plan.push_back('{PH_FETCH, 1'b0, (i % (T + 1)) == T});
    plan.push_back('{PH_FETCH, 1'b1, 1'b0});
    plan.push_back('{PH_DECODE, 1'($urandom), 1'b0});
    if (is_legal(op)) begin
      plan.push_back('{PH_EXEC, 1'($urandom), 1'b0});
      if (op == BEQ_OP || op == BNE_OP) begin
        retires = 1'b1;
      end else if (op == LW_OP || op == SW_OP) begin
        int  i         = 0;
        bit  done      = 1'b0;
        bit  completed = 1'b0;
        while (!done) begin
          if (i == mw) begin
            plan.push_back('{PH_MEM, 1'b1, 1'b0});
            done = 1'b1;
            completed = 1'b1;
          end else if (i == T) begin
            plan.push_back('{PH_MEM, 1'b0, 1'b1});
            done = 1'b1;
          end else begin
            plan.push_back('{PH_MEM, 1'b0, 1'b0});
          end
          i++;
        end
        if (completed) begin
          if (op == LW_OP) plan.push_back('{PH_WB, 1'($urandom), 1'b0});
          retires = 1'b1;
        end
      end else begin
        plan.push_back('{PH_WB, 1'($urandom), 1'b0});
        retires = 1'b1;
      end
    end

    for (int k = 0; k < plan.size(); k++) begin
      ph  = plan[k].ph;
      drv = (ph == PH_DECODE) ? op : 6'($urandom);
      step(drv, plan[k].rdy, obs);
      e = expect_vec(ph, op, plan[k].rdy, plan[k].to);
      checks++;
      if (obs !== e) begin
        errors++;
        $display("FAIL %s cycle %0d %s: outputs got %h want %h", tag, k, ph.name(), obs, e);
      end
    end

    if (retires) ret_model++;
    checks++;
    if (bus.retired_o !== RET_W'(ret_model)) begin
      errors++;
      $display("FAIL %s retired: got %0d want %0d", tag, bus.retired_o, RET_W'(ret_model));
    end
  endtask

  task automatic test_reset();
    vec_t obs;
    rst_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(LW_OP, 1'b1, obs);
      checks++;
      if (obs !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %h want 0", obs);
      end
    end
    rst_i     = 1'b1;
    ret_model = 0;
    checks++;
    if (bus.retired_o !== '0) begin
      errors++;
      $display("FAIL reset_retired: got %0d want 0", bus.retired_o);
    end
  endtask

  task automatic test_addi();
    run_instr(ADDI_OP, 0, 0, "addi");
    checks++;
    if (bus.retired_o !== RET_W'(1)) begin
      errors++;
      $display("FAIL addi_retired_first: got %0d want 1", bus.retired_o);
    end
  endtask

  task automatic test_lw_wait();
    run_instr(LW_OP, 0, 3, "lw_wait3");
    run_instr(LW_OP, 2, 0, "lw_fetch_wait");
  endtask

  task automatic test_branch();
    run_instr(BEQ_OP, 0, 0, "beq");
    run_instr(BNE_OP, 1, 0, "bne");
  endtask

  task automatic test_illegal();
    run_instr(6'h3F, 0, 0, "illegal_3f");
    for (int i = 0; i < 4; i++) begin
      logic [5:0] op;
      do op = 6'($urandom); while (is_legal(op));
      run_instr(op, 0, 0, "illegal_rand");
    end
  endtask

  task automatic test_timeout();
    run_instr(SW_OP, 0, 20, "sw_timeout");
    run_instr(SW_OP, 0, T, "sw_ready_on_limit");
    run_instr(LW_OP, 0, T + 3, "lw_timeout");
    run_instr(LW_OP, 0, T - 1, "lw_below_limit");
    run_instr(ADDI_OP, T + 3, 0, "fetch_timeout");
    run_instr(SW_OP, T, 1, "fetch_ready_on_limit");
  endtask

  task automatic test_wrap();
    vec_t obs;
    rst_i = 1'b0;
    step(6'($urandom), 1'b1, obs);
    rst_i     = 1'b1;
    ret_model = 0;
    for (int i = 0; i < 3; i++) run_instr(R_OP, 0, 0, "rtype_preset");
    checks++;
    if (bus.retired_o !== RET_W'(3)) begin
      errors++;
      $display("FAIL wrap_preset: got %0d want 3", bus.retired_o);
    end
    run_instr(R_OP, 0, 0, "rtype_wrap");
    checks++;
    if (bus.retired_o !== '0) begin
      errors++;
      $display("FAIL wrap_to_zero: got %0d want 0", bus.retired_o);
    end
  endtask

  task automatic test_mid_reset();
    vec_t obs, e;
    run_instr(ADDI_OP, 0, 0, "pre_reset_addi");
    step(6'($urandom), 1'b1, obs);
    step(LW_OP, 1'($urandom), obs);
    step(6'($urandom), 1'($urandom), obs);
    step(6'($urandom), 1'b0, obs);
    e = expect_vec(PH_MEM, LW_OP, 1'b0, 1'b0);
    checks++;
    if (obs !== e) begin
      errors++;
      $display("FAIL mid_reset_in_mem: got %h want %h", obs, e);
    end
    rst_i = 1'b0;
    step(6'($urandom), 1'b1, obs);
    checks++;
    if (obs !== '0) begin
      errors++;
      $display("FAIL mid_reset_forced: got %h want 0", obs);
    end
    rst_i     = 1'b1;
    ret_model = 0;
    checks++;
    if (bus.retired_o !== '0) begin
      errors++;
      $display("FAIL mid_reset_retired: got %0d want 0", bus.retired_o);
    end
    run_instr(SW_OP, 0, 0, "post_reset_sw");
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [5:0] op;
      int fw, mw;
      op = ($urandom_range(0, 4) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 8)];
      fw = ($urandom_range(0, 3) == 0) ? $urandom_range(0, T + 3) : 0;
      mw = $urandom_range(0, T + 2);
      run_instr(op, fw, mw, "random");
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_wrap();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
